// File: rtl/memory_arbiter_pkg.sv
// Shared memory-port signalling used between fetch/decode stages and the memory bus.
package memory_arbiter_pkg;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

endpackage

// File: rtl/memory_arbiter.sv
// Two-port arbiter for the single memory port: fetch and load/store requests are
// buffered one-deep, issued one at a time round-robin, and responses routed to the owner.
module memory_arbiter
  import memory_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  mem_in,
  input  mem_out_type mem_out,
  output logic [1:0]  dbg_state_o
);

  // Requester handshake: a request is a one-cycle mem_valid pulse; the requester
  // holds off until it sees its own one-cycle mem_ready, which carries mem_rdata.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_I = 2'd1,
    S_BUSY_D = 2'd2
  } state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;

  logic        ipend_q, ipend_d;
  logic [31:0] iaddr_q, iaddr_d;
  logic [31:0] iwdata_q, iwdata_d;

  logic        dpend_q, dpend_d;
  logic [31:0] daddr_q, daddr_d;
  logic [31:0] dwdata_q, dwdata_d;
  logic [3:0]  dwstrb_q, dwstrb_d;

  logic        grant_i, grant_d;
  logic        done_i, done_d;

  // Fetch strobes are forced to zero and the instr flags are implied by the port.
  logic        unused_inputs;
  assign unused_inputs = ^{imem_in.mem_instr, imem_in.mem_wstrb, dmem_in.mem_instr};

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == S_IDLE) begin
      grant_i = ipend_q && (!dpend_q || (last_grant_q == GRANT_D));
      grant_d = dpend_q && (!ipend_q || (last_grant_q == GRANT_I));
    end
    done_i = (state_q == S_BUSY_I) && mem_out.mem_ready;
    done_d = (state_q == S_BUSY_D) && mem_out.mem_ready;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    if (grant_i) begin
      state_d      = S_BUSY_I;
      last_grant_d = GRANT_I;
    end else if (grant_d) begin
      state_d      = S_BUSY_D;
      last_grant_d = GRANT_D;
    end else if (done_i || done_d) begin
      state_d = S_IDLE;
    end

    // A request landing on the completion edge of the same port is taken, not dropped.
    ipend_d  = ipend_q && !done_i;
    iaddr_d  = iaddr_q;
    iwdata_d = iwdata_q;
    if (imem_in.mem_valid && (!ipend_q || done_i)) begin
      ipend_d  = 1'b1;
      iaddr_d  = imem_in.mem_addr;
      iwdata_d = imem_in.mem_wdata;
    end

    dpend_d  = dpend_q && !done_d;
    daddr_d  = daddr_q;
    dwdata_d = dwdata_q;
    dwstrb_d = dwstrb_q;
    if (dmem_in.mem_valid && (!dpend_q || done_d)) begin
      dpend_d  = 1'b1;
      daddr_d  = dmem_in.mem_addr;
      dwdata_d = dmem_in.mem_wdata;
      dwstrb_d = dmem_in.mem_wstrb;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= GRANT_I;
      ipend_q      <= 1'b0;
      iaddr_q      <= '0;
      iwdata_q     <= '0;
      dpend_q      <= 1'b0;
      daddr_q      <= '0;
      dwdata_q     <= '0;
      dwstrb_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      ipend_q      <= ipend_d;
      iaddr_q      <= iaddr_d;
      iwdata_q     <= iwdata_d;
      dpend_q      <= dpend_d;
      daddr_q      <= daddr_d;
      dwdata_q     <= dwdata_d;
      dwstrb_q     <= dwstrb_d;
    end
  end

  always_comb begin
    mem_in   = '0;
    imem_out = '0;
    dmem_out = '0;
    if (grant_i) begin
      mem_in.mem_valid = 1'b1;
      mem_in.mem_instr = 1'b1;
      mem_in.mem_addr  = iaddr_q;
      mem_in.mem_wdata = iwdata_q;
      mem_in.mem_wstrb = 4'h0;
    end else if (grant_d) begin
      mem_in.mem_valid = 1'b1;
      mem_in.mem_instr = 1'b0;
      mem_in.mem_addr  = daddr_q;
      mem_in.mem_wdata = dwdata_q;
      mem_in.mem_wstrb = dwstrb_q;
    end
    if (done_i) begin
      imem_out.mem_ready = 1'b1;
      imem_out.mem_rdata = mem_out.mem_rdata;
    end
    if (done_d) begin
      dmem_out.mem_ready = 1'b1;
      dmem_out.mem_rdata = mem_out.mem_rdata;
    end
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed cycle table, hand sequences for corner cases,
// and a randomized run checked against a transaction-level model.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BI   = 2'd1;
  localparam logic [1:0] ST_BD   = 2'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  mem_in_type  imem_in, dmem_in, mem_in;
  mem_out_type imem_out, dmem_out, mem_out;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  memory_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .imem_in     (imem_in),
    .imem_out    (imem_out),
    .dmem_in     (dmem_in),
    .dmem_out    (dmem_out),
    .mem_in      (mem_in),
    .mem_out     (mem_out),
    .dbg_state_o (dbg_state)
  );

  typedef struct {
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic [31:0] da;
    logic [31:0] dw;
    logic [3:0]  ds;
    logic        mr;
    logic [31:0] md;
    logic        e_mv;
    logic        e_mi;
    logic [31:0] e_ma;
    logic [31:0] e_mw;
    logic [3:0]  e_ms;
    logic        e_ir;
    logic [31:0] e_id;
    logic        e_dr;
    logic [31:0] e_dd;
    logic [1:0]  e_st;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  vec_t vecs[8];
  req_t i_q[$];
  req_t d_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    imem_in.mem_valid = 1'b0;
    dmem_in.mem_valid = 1'b0;
    mem_out.mem_ready = 1'b0;
    mem_out.mem_rdata = '0;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic        g_any, g_d, completing, ip, dp, out_busy, out_is_d, last_d;
    logic        exp_ir, exp_dr;
    int          cnt, dcount, n_issue;
    req_t        r;

    imem_in = '0;
    dmem_in = '0;
    mem_out = '0;
    imem_in.mem_instr = 1'b1;

    vecs[0] = '{1'b1, 32'h100, 1'b1, 32'h200, 32'h11223344, 4'h3, 1'b0, '0,
                1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, ST_IDLE};
    vecs[1] = '{1'b0, '0, 1'b0, '0, '0, '0, 1'b0, '0,
                1'b1, 1'b0, 32'h200, 32'h11223344, 4'h3, 1'b0, '0, 1'b0, '0, ST_IDLE};
    vecs[2] = '{1'b0, '0, 1'b1, 32'h300, 32'h55667788, 4'h0, 1'b1, 32'hA1,
                1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 32'hA1, ST_BD};
    vecs[3] = '{1'b0, '0, 1'b0, '0, '0, '0, 1'b0, '0,
                1'b1, 1'b1, 32'h100, '0, 4'h0, 1'b0, '0, 1'b0, '0, ST_IDLE};
    vecs[4] = '{1'b0, '0, 1'b0, '0, '0, '0, 1'b1, 32'hB2,
                1'b0, 1'b0, '0, '0, '0, 1'b1, 32'hB2, 1'b0, '0, ST_BI};
    vecs[5] = '{1'b0, '0, 1'b0, '0, '0, '0, 1'b0, '0,
                1'b1, 1'b0, 32'h300, 32'h55667788, 4'h0, 1'b0, '0, 1'b0, '0, ST_IDLE};
    vecs[6] = '{1'b0, '0, 1'b0, '0, '0, '0, 1'b1, 32'hC3,
                1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 32'hC3, ST_BD};
    vecs[7] = '{1'b0, '0, 1'b0, '0, '0, '0, 1'b0, '0,
                1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, ST_IDLE};

    // Reset: outputs stay zero even with activity on the inputs.
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    imem_in.mem_valid = 1'b1;
    mem_out.mem_ready = 1'b1;
    settle();
    chk("rst_mem_valid", 32'(mem_in.mem_valid), 32'd0);
    chk("rst_mem_addr", mem_in.mem_addr, 32'd0);
    chk("rst_imem_ready", 32'(imem_out.mem_ready), 32'd0);
    chk("rst_dmem_ready", 32'(dmem_out.mem_ready), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    next_cycle();
    rst = 1'b1;
    settle();
    chk("rst_no_capture", 32'(mem_in.mem_valid), 32'd0);

    // Contention table: data wins first, data re-requests on its completion, fetch wins next.
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      imem_in.mem_valid = vecs[i].iv;
      imem_in.mem_addr  = vecs[i].ia;
      imem_in.mem_wdata = '0;
      imem_in.mem_wstrb = 4'hF;
      dmem_in.mem_valid = vecs[i].dv;
      dmem_in.mem_addr  = vecs[i].da;
      dmem_in.mem_wdata = vecs[i].dw;
      dmem_in.mem_wstrb = vecs[i].ds;
      mem_out.mem_ready = vecs[i].mr;
      mem_out.mem_rdata = vecs[i].md;
      settle();
      chk($sformatf("tbl%0d_mv", i), 32'(mem_in.mem_valid), 32'(vecs[i].e_mv));
      if (vecs[i].e_mv) begin
        chk($sformatf("tbl%0d_instr", i), 32'(mem_in.mem_instr), 32'(vecs[i].e_mi));
        chk($sformatf("tbl%0d_addr", i), mem_in.mem_addr, vecs[i].e_ma);
        chk($sformatf("tbl%0d_wdata", i), mem_in.mem_wdata, vecs[i].e_mw);
        chk($sformatf("tbl%0d_wstrb", i), 32'(mem_in.mem_wstrb), 32'(vecs[i].e_ms));
      end
      chk($sformatf("tbl%0d_iready", i), 32'(imem_out.mem_ready), 32'(vecs[i].e_ir));
      chk($sformatf("tbl%0d_dready", i), 32'(dmem_out.mem_ready), 32'(vecs[i].e_dr));
      if (vecs[i].e_ir || vecs[i].e_st != ST_BI)
        chk($sformatf("tbl%0d_irdata", i), imem_out.mem_rdata, vecs[i].e_id);
      if (vecs[i].e_dr || vecs[i].e_st != ST_BD)
        chk($sformatf("tbl%0d_drdata", i), dmem_out.mem_rdata, vecs[i].e_dd);
      chk($sformatf("tbl%0d_state", i), 32'(dbg_state), 32'(vecs[i].e_st));
    end

    // Single fetch, L=1.
    next_cycle();
    imem_in.mem_valid = 1'b1;
    imem_in.mem_addr  = 32'h0000_0100;
    settle();
    chk("fetch_c0_mv", 32'(mem_in.mem_valid), 32'd0);
    next_cycle();
    settle();
    chk("fetch_c1_mv", 32'(mem_in.mem_valid), 32'd1);
    chk("fetch_c1_instr", 32'(mem_in.mem_instr), 32'd1);
    chk("fetch_c1_addr", mem_in.mem_addr, 32'h0000_0100);
    chk("fetch_c1_wstrb", 32'(mem_in.mem_wstrb), 32'd0);
    next_cycle();
    mem_out.mem_ready = 1'b1;
    mem_out.mem_rdata = 32'h0000_0013;
    settle();
    chk("fetch_c2_iready", 32'(imem_out.mem_ready), 32'd1);
    chk("fetch_c2_irdata", imem_out.mem_rdata, 32'h13);
    chk("fetch_c2_dready", 32'(dmem_out.mem_ready), 32'd0);
    chk("fetch_c2_drdata", dmem_out.mem_rdata, 32'd0);
    next_cycle();
    settle();
    chk("fetch_c3_iready", 32'(imem_out.mem_ready), 32'd0);
    chk("fetch_c3_state", 32'(dbg_state), 32'(ST_IDLE));

    // Single store, L=3.
    next_cycle();
    dmem_in.mem_valid = 1'b1;
    dmem_in.mem_addr  = 32'h8000_0004;
    dmem_in.mem_wdata = 32'hDEAD_BEEF;
    dmem_in.mem_wstrb = 4'hF;
    settle();
    next_cycle();
    settle();
    chk("store_mv", 32'(mem_in.mem_valid), 32'd1);
    chk("store_instr", 32'(mem_in.mem_instr), 32'd0);
    chk("store_addr", mem_in.mem_addr, 32'h8000_0004);
    chk("store_wdata", mem_in.mem_wdata, 32'hDEAD_BEEF);
    chk("store_wstrb", 32'(mem_in.mem_wstrb), 32'hF);
    dcount = 0;
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      if (k == 2) mem_out.mem_ready = 1'b1;
      settle();
      if (k < 3) chk("store_busy_mv", 32'(mem_in.mem_valid), 32'd0);
      chk("store_iready", 32'(imem_out.mem_ready), 32'd0);
      dcount += int'(dmem_out.mem_ready);
    end
    chk("store_ready_count", 32'(dcount), 32'd1);

    // Protocol guard: a second pulse while pending is dropped.
    next_cycle();
    dmem_in.mem_valid = 1'b1;
    dmem_in.mem_addr  = 32'h20;
    settle();
    next_cycle();
    dmem_in.mem_valid = 1'b1;
    dmem_in.mem_addr  = 32'h40;
    settle();
    chk("guard_addr", mem_in.mem_addr, 32'h20);
    dcount  = 0;
    n_issue = 0;
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      if (k == 0) begin
        dmem_in.mem_valid = 1'b1;
        dmem_in.mem_addr  = 32'h40;
      end
      if (k == 1) mem_out.mem_ready = 1'b1;
      settle();
      n_issue += int'(mem_in.mem_valid);
      dcount  += int'(dmem_out.mem_ready);
    end
    chk("guard_extra_issue", 32'(n_issue), 32'd0);
    chk("guard_ready_count", 32'(dcount), 32'd1);

    // Spurious memory ready while idle.
    next_cycle();
    mem_out.mem_ready = 1'b1;
    mem_out.mem_rdata = 32'hFFFF_FFFF;
    settle();
    chk("spur_iready", 32'(imem_out.mem_ready), 32'd0);
    chk("spur_dready", 32'(dmem_out.mem_ready), 32'd0);
    chk("spur_irdata", imem_out.mem_rdata, 32'd0);
    chk("spur_drdata", dmem_out.mem_rdata, 32'd0);
    chk("spur_mv", 32'(mem_in.mem_valid), 32'd0);
    chk("spur_state", 32'(dbg_state), 32'(ST_IDLE));
    next_cycle();
    settle();
    chk("spur_state_after", 32'(dbg_state), 32'(ST_IDLE));

    // Reset in BUSY_D, then a late ready, then normal traffic.
    next_cycle();
    dmem_in.mem_valid = 1'b1;
    dmem_in.mem_addr  = 32'h60;
    settle();
    next_cycle();
    settle();
    next_cycle();
    settle();
    chk("mrst_pre_state", 32'(dbg_state), 32'(ST_BD));
    rst = 1'b0;
    settle();
    chk("mrst_mv", 32'(mem_in.mem_valid), 32'd0);
    chk("mrst_addr", mem_in.mem_addr, 32'd0);
    chk("mrst_state", 32'(dbg_state), 32'(ST_IDLE));
    next_cycle();
    rst = 1'b1;
    settle();
    next_cycle();
    mem_out.mem_ready = 1'b1;
    mem_out.mem_rdata = 32'h77;
    settle();
    chk("mrst_late_iready", 32'(imem_out.mem_ready), 32'd0);
    chk("mrst_late_dready", 32'(dmem_out.mem_ready), 32'd0);
    next_cycle();
    settle();
    chk("mrst_no_reissue", 32'(mem_in.mem_valid), 32'd0);
    next_cycle();
    imem_in.mem_valid = 1'b1;
    imem_in.mem_addr  = 32'h500;
    dmem_in.mem_valid = 1'b1;
    dmem_in.mem_addr  = 32'h600;
    settle();
    next_cycle();
    settle();
    chk("mrst_first_grant_instr", 32'(mem_in.mem_instr), 32'd0);
    chk("mrst_first_grant_addr", mem_in.mem_addr, 32'h600);
    next_cycle();
    mem_out.mem_ready = 1'b1;
    settle();
    next_cycle();
    settle();
    chk("mrst_fetch_grant", 32'(mem_in.mem_valid & mem_in.mem_instr), 32'd1);
    next_cycle();
    mem_out.mem_ready = 1'b1;
    mem_out.mem_rdata = 32'h13;
    settle();
    chk("mrst_fetch_ready", 32'(imem_out.mem_ready), 32'd1);
    chk("mrst_fetch_rdata", imem_out.mem_rdata, 32'h13);

    // Randomized traffic against a transaction-level model.
    next_cycle();
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    i_q.delete();
    d_q.delete();
    out_busy = 1'b0;
    out_is_d = 1'b0;
    last_d   = 1'b0;
    cnt      = 0;
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      g_any      = !out_busy && (i_q.size() != 0 || d_q.size() != 0);
      g_d        = g_any && d_q.size() != 0 && (i_q.size() == 0 || !last_d);
      completing = out_busy && cnt == 0;
      mem_out.mem_ready = completing || (!out_busy && !g_any && $urandom_range(0, 7) == 0);
      mem_out.mem_rdata = $urandom;
      ip = ($urandom_range(0, 3) == 0);
      dp = ($urandom_range(0, 3) == 0);
      imem_in.mem_valid = ip;
      imem_in.mem_addr  = $urandom;
      imem_in.mem_wdata = $urandom;
      imem_in.mem_wstrb = 4'($urandom);
      dmem_in.mem_valid = dp;
      dmem_in.mem_addr  = $urandom;
      dmem_in.mem_wdata = $urandom;
      dmem_in.mem_wstrb = 4'($urandom);
      settle();

      chk("rnd_mv", 32'(mem_in.mem_valid), 32'(g_any));
      if (g_any) begin
        r = g_d ? d_q[0] : i_q[0];
        chk("rnd_instr", 32'(mem_in.mem_instr), 32'(!g_d));
        chk("rnd_addr", mem_in.mem_addr, r.addr);
        chk("rnd_wdata", mem_in.mem_wdata, r.wdata);
        chk("rnd_wstrb", 32'(mem_in.mem_wstrb), g_d ? 32'(r.wstrb) : 32'd0);
      end
      exp_ir = completing && !out_is_d;
      exp_dr = completing && out_is_d;
      chk("rnd_iready", 32'(imem_out.mem_ready), 32'(exp_ir));
      chk("rnd_dready", 32'(dmem_out.mem_ready), 32'(exp_dr));
      if (exp_ir || !(out_busy && !out_is_d))
        chk("rnd_irdata", imem_out.mem_rdata, exp_ir ? mem_out.mem_rdata : 32'd0);
      if (exp_dr || !(out_busy && out_is_d))
        chk("rnd_drdata", dmem_out.mem_rdata, exp_dr ? mem_out.mem_rdata : 32'd0);

      if (completing) begin
        if (out_is_d) void'(d_q.pop_front());
        else void'(i_q.pop_front());
        out_busy = 1'b0;
      end
      if (ip && i_q.size() == 0)
        i_q.push_back('{imem_in.mem_addr, imem_in.mem_wdata, imem_in.mem_wstrb});
      if (dp && d_q.size() == 0)
        d_q.push_back('{dmem_in.mem_addr, dmem_in.mem_wdata, dmem_in.mem_wstrb});
      if (g_any) begin
        out_busy = 1'b1;
        out_is_d = g_d;
        last_d   = g_d;
        cnt      = $urandom_range(0, 3);
      end else if (out_busy) begin
        cnt--;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
